// File: rtl/hd44780_responder_if.sv
// 8-bit HD44780 LCD bus as seen between an initiator (master) and the
// responder (slave).
interface hd44780_responder_if;
   logic       lcd_en;
   logic       lcd_regsel;
   logic       lcd_r1w0;
   logic [7:0] lcd_data_in;
   logic [7:0] lcd_data_out;
   logic       lcd_data_oe;

   modport master (
      output lcd_en, lcd_regsel, lcd_r1w0, lcd_data_in,
      input  lcd_data_out, lcd_data_oe
   );

   modport slave (
      input  lcd_en, lcd_regsel, lcd_r1w0, lcd_data_in,
      output lcd_data_out, lcd_data_oe
   );
endinterface

// File: rtl/hd44780_responder.sv
// HD44780-compatible LCD controller model: synchronized bus decode, 2x40 DDRAM,
// address counter with line wrap, busy timing and busy-flag/data reads.
module hd44780_responder #(
   parameter int unsigned BUSY_CYCLES  = 1850,
   parameter int unsigned CLEAR_CYCLES = 76000,
   parameter int unsigned INIT_CYCLES  = 750000
) (
   input  logic               clk,
   input  logic               reset,
   hd44780_responder_if.slave lcd,
   output logic               busy,
   output logic               disp_on,
   output logic               cursor_on,
   output logic               blink_on,
   output logic               protocol_err,
   input  logic [6:0]         dbg_addr,
   output logic [7:0]         dbg_char
);

   localparam int unsigned MaxAB     = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
   localparam int unsigned MaxCycles = (MaxAB > INIT_CYCLES) ? MaxAB : INIT_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);
   localparam int unsigned Cells     = 80;

   typedef enum logic [0:0] {StRun, StFill} state_e;

   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
      if (up) begin
         case (ac)
            7'h27:   return 7'h40;
            7'h67:   return 7'h00;
            default: return ac + 7'd1;
         endcase
      end else begin
         case (ac)
            7'h40:   return 7'h27;
            7'h00:   return 7'h67;
            default: return ac - 7'd1;
         endcase
      end
   endfunction

   function automatic logic [6:0] cell_idx(input logic [6:0] a);
      return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
   endfunction

   function automatic logic addr_ok(input logic [6:0] a);
      return a[5:0] <= 6'd39;
   endfunction

   // Bus packed as {en, regsel, r1w0, data}; prev_q holds the cycle before sync2_q.
   logic [10:0]     sync1_q, sync2_q, prev_q;
   state_e          state_q, state_d;
   logic [6:0]      fill_q, fill_d;
   logic            clr_q, clr_d;
   logic [6:0]      ac_q, ac_d;
   logic            id_q, id_d;
   logic            disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
   logic            err_q, err_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]      out_q, out_d;
   logic            oe_q, oe_d;
   logic [7:0]      dbg_q, dbg_d;
   logic [7:0]      mem [Cells];
   logic            mem_we;
   logic [6:0]      mem_idx;
   logic [7:0]      mem_wdata;

   logic       en_s, sel_s, rw_s, en_p, sel_p, rw_p, xfer;
   logic [7:0] data_p;

   assign en_s   = sync2_q[10];
   assign sel_s  = sync2_q[9];
   assign rw_s   = sync2_q[8];
   assign en_p   = prev_q[10];
   assign sel_p  = prev_q[9];
   assign rw_p   = prev_q[8];
   assign data_p = prev_q[7:0];
   assign xfer   = en_p & ~en_s;

   assign busy         = (cnt_q != '0);
   assign disp_on      = disp_q;
   assign cursor_on    = cur_q;
   assign blink_on     = blink_q;
   assign protocol_err = err_q;
   assign dbg_char     = dbg_q;
   assign lcd.lcd_data_out = out_q;
   assign lcd.lcd_data_oe  = oe_q;

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      clr_d     = clr_q;
      ac_d      = ac_q;
      id_d      = id_q;
      disp_d    = disp_q;
      cur_d     = cur_q;
      blink_d   = blink_q;
      err_d     = err_q;
      cnt_d     = busy ? cnt_q - CntW'(1) : cnt_q;
      mem_we    = 1'b0;
      mem_idx   = fill_q;
      mem_wdata = 8'h20;

      oe_d  = en_s & rw_s;
      out_d = !oe_d ? 8'h00 : (sel_s ? mem[cell_idx(ac_q)] : {busy, ac_q});
      dbg_d = addr_ok(dbg_addr) ? mem[cell_idx(dbg_addr)] : 8'h00;

      if (xfer) begin
         if (rw_p) begin
            if (sel_p) ac_d = ac_step(ac_q, id_q);
         end else if (busy) begin
            err_d = 1'b1;
         end else begin
            cnt_d = (!sel_p && data_p inside {8'h01, 8'h02, 8'h03}) ?
                    CntW'(CLEAR_CYCLES) : CntW'(BUSY_CYCLES);
            if (sel_p) begin
               mem_we    = 1'b1;
               mem_idx   = cell_idx(ac_q);
               mem_wdata = data_p;
               ac_d      = ac_step(ac_q, id_q);
            end else if (data_p[7]) begin
               if (addr_ok(data_p[6:0])) ac_d = data_p[6:0];
               else err_d = 1'b1;
            end else if (data_p[6]) begin
               // CGRAM address: accepted, nothing modelled
            end else if (data_p[5]) begin
               if (!data_p[4]) err_d = 1'b1;
            end else if (data_p[4]) begin
               if (!data_p[3]) ac_d = ac_step(ac_q, data_p[2]);
            end else if (data_p[3]) begin
               disp_d  = data_p[2];
               cur_d   = data_p[1];
               blink_d = data_p[0];
            end else if (data_p[2]) begin
               id_d = data_p[1];
               if (data_p[0]) err_d = 1'b1;
            end else if (data_p[1]) begin
               ac_d = 7'h00;
            end else if (data_p[0]) begin
               state_d = StFill;
               fill_d  = 7'd0;
               clr_d   = 1'b1;
            end
         end
      end

      // Fill runs only while busy, so it never collides with a data write.
      unique case (state_q)
         StFill: begin
            mem_we    = 1'b1;
            mem_idx   = fill_q;
            mem_wdata = 8'h20;
            if (fill_q == 7'(Cells - 1)) begin
               state_d = StRun;
               fill_d  = 7'd0;
               if (clr_q) begin
                  ac_d  = 7'h00;
                  id_d  = 1'b1;
                  clr_d = 1'b0;
               end
            end else begin
               fill_d = fill_q + 7'd1;
            end
         end
         StRun: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         state_q <= StFill;
         fill_q  <= 7'd0;
         clr_q   <= 1'b0;
         ac_q    <= 7'h00;
         id_q    <= 1'b1;
         disp_q  <= 1'b0;
         cur_q   <= 1'b0;
         blink_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= CntW'(INIT_CYCLES);
         out_q   <= 8'h00;
         oe_q    <= 1'b0;
         dbg_q   <= 8'h00;
      end else begin
         sync1_q <= {lcd.lcd_en, lcd.lcd_regsel, lcd.lcd_r1w0, lcd.lcd_data_in};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         fill_q  <= fill_d;
         clr_q   <= clr_d;
         ac_q    <= ac_d;
         id_q    <= id_d;
         disp_q  <= disp_d;
         cur_q   <= cur_d;
         blink_q <= blink_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
         dbg_q   <= dbg_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_idx] <= mem_wdata;
   end

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed bench for hd44780_responder: init fill, command decode, AC wrap,
// busy timing, protocol errors, clear and mid-clear reset.
module tb_hd44780_responder;
   logic       clk = 1'b0;
   logic       reset;
   logic       busy, disp_on, cursor_on, blink_on, protocol_err;
   logic [6:0] dbg_addr;
   logic [7:0] dbg_char;
   logic [7:0] rd;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         t0;
   int         n;

   hd44780_responder_if bus ();

   hd44780_responder #(
      .BUSY_CYCLES  (20),
      .CLEAR_CYCLES (200),
      .INIT_CYCLES  (100)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .lcd          (bus),
      .busy         (busy),
      .disp_on      (disp_on),
      .cursor_on    (cursor_on),
      .blink_on     (blink_on),
      .protocol_err (protocol_err),
      .dbg_addr     (dbg_addr),
      .dbg_char     (dbg_char)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic sel, input logic [7:0] d);
      @(negedge clk);
      bus.lcd_regsel  = sel;
      bus.lcd_r1w0    = 1'b0;
      bus.lcd_data_in = d;
      bus.lcd_en      = 1'b1;
      repeat (4) @(negedge clk);
      bus.lcd_en = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic bus_read(input logic sel, output logic [7:0] d);
      @(negedge clk);
      bus.lcd_regsel = sel;
      bus.lcd_r1w0   = 1'b1;
      bus.lcd_en     = 1'b1;
      repeat (4) @(negedge clk);
      d = bus.lcd_data_out;
      check_eq("rd_oe", bus.lcd_data_oe, 1'b1);
      bus.lcd_en = 1'b0;
      repeat (4) @(negedge clk);
      bus.lcd_r1w0 = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 1000; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check_eq("wait_idle", busy, 1'b0);
   endtask

   task automatic wr_idle(input logic sel, input logic [7:0] d);
      bus_write(sel, d);
      wait_idle();
   endtask

   task automatic peek(input logic [6:0] a, input logic [7:0] exp, input string tag);
      dbg_addr = a;
      @(negedge clk);
      @(negedge clk);
      check_eq(tag, dbg_char, exp);
   endtask

   task automatic check_reset_vals();
      check_eq("rst_busy", busy, 1'b1);
      check_eq("rst_dout", bus.lcd_data_out, 8'h00);
      check_eq("rst_oe", bus.lcd_data_oe, 1'b0);
      check_eq("rst_disp", disp_on, 1'b0);
      check_eq("rst_cursor", cursor_on, 1'b0);
      check_eq("rst_blink", blink_on, 1'b0);
      check_eq("rst_err", protocol_err, 1'b0);
      check_eq("rst_dbg", dbg_char, 8'h00);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: sim time %0t, required finish earlier", $time);
      $fatal(1);
   end

   initial begin
      bus.lcd_en      = 1'b0;
      bus.lcd_regsel  = 1'b0;
      bus.lcd_r1w0    = 1'b0;
      bus.lcd_data_in = 8'h00;
      dbg_addr        = 7'h00;
      reset           = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals();

      // Init: busy exactly 100 cycles, DDRAM filled with spaces
      reset = 1'b0;
      t0    = cyc;
      bus_read(1'b0, rd);
      check_eq("init_bf_busy", rd, 8'h80);
      wait_idle();
      check_eq("init_len", cyc - t0, 100);
      bus_read(1'b0, rd);
      check_eq("init_bf_idle", rd, 8'h00);
      peek(7'h00, 8'h20, "init_cell_00");
      peek(7'h67, 8'h20, "init_cell_67");
      peek(7'h28, 8'h00, "dbg_invalid");

      // Function set, display control, first data byte
      wr_idle(1'b0, 8'h38);
      wr_idle(1'b0, 8'h0E);
      wr_idle(1'b1, 8'h41);
      check_eq("disp_on", disp_on, 1'b1);
      check_eq("cursor_on", cursor_on, 1'b1);
      check_eq("blink_off", blink_on, 1'b0);
      peek(7'h00, 8'h41, "cell_00_A");
      bus_read(1'b0, rd);
      check_eq("bf_ac01", rd, 8'h01);

      // Increment wrap 0x27 -> 0x40, then decrement wrap 0x40 -> 0x27
      wr_idle(1'b0, 8'hA7);
      wr_idle(1'b1, 8'h5A);
      bus_read(1'b0, rd);
      check_eq("bf_wrap_inc", rd, 8'h40);
      peek(7'h27, 8'h5A, "cell_27");
      wr_idle(1'b0, 8'h04);
      wr_idle(1'b1, 8'h33);
      peek(7'h40, 8'h33, "cell_40");
      bus_read(1'b0, rd);
      check_eq("bf_wrap_dec", rd, 8'h27);

      // Data read moves AC (decrement 0x00 -> 0x67), cursor shift right wraps back
      wr_idle(1'b0, 8'h80);
      bus_read(1'b1, rd);
      check_eq("data_rd", rd, 8'h41);
      bus_read(1'b0, rd);
      check_eq("bf_rd_dec", rd, 8'h67);
      wr_idle(1'b0, 8'h14);
      bus_read(1'b0, rd);
      check_eq("bf_shift_wrap", rd, 8'h00);
      check_eq("err_clean", protocol_err, 1'b0);

      // Write while busy is dropped and flagged
      bus_write(1'b0, 8'h06);
      bus_write(1'b1, 8'h42);
      wait_idle();
      check_eq("err_busy_wr", protocol_err, 1'b1);
      peek(7'h00, 8'h41, "cell_00_kept");
      bus_read(1'b0, rd);
      check_eq("bf_busy_wr", rd, 8'h00);

      // Reset clears the sticky flag; bad DDRAM address flags and keeps AC
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("err_rst_clr", protocol_err, 1'b0);
      reset = 1'b0;
      wait_idle();
      wr_idle(1'b0, 8'hA8);
      check_eq("err_bad_addr", protocol_err, 1'b1);
      bus_read(1'b0, rd);
      check_eq("bf_bad_addr", rd, 8'h00);

      // Clear display: 200 busy cycles, spaces everywhere, AC=0, I/D=1
      wr_idle(1'b1, 8'h11);
      wr_idle(1'b1, 8'h22);
      wr_idle(1'b1, 8'h33);
      peek(7'h01, 8'h22, "cell_01");
      wr_idle(1'b0, 8'h04);
      @(negedge clk);
      bus.lcd_regsel  = 1'b0;
      bus.lcd_r1w0    = 1'b0;
      bus.lcd_data_in = 8'h01;
      bus.lcd_en      = 1'b1;
      repeat (4) @(negedge clk);
      bus.lcd_en = 1'b0;
      n = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (busy) n++;
         else if (n > 0) break;
      end
      check_eq("clear_len", n, 200);
      for (int i = 0; i < 40; i++) begin
         peek(7'(i), 8'h20, "clr_cell_l0");
         peek(7'(8'h40 + i), 8'h20, "clr_cell_l1");
      end
      bus_read(1'b0, rd);
      check_eq("clr_ac", rd, 8'h00);
      wr_idle(1'b1, 8'h55);
      bus_read(1'b0, rd);
      check_eq("clr_id_inc", rd, 8'h01);

      // Reset in the middle of a clear restarts the init sequence
      wr_idle(1'b0, 8'hE7);
      wr_idle(1'b1, 8'h77);
      peek(7'h67, 8'h77, "cell_67");
      wr_idle(1'b0, 8'h0F);
      check_eq("blink_on", blink_on, 1'b1);
      bus_write(1'b0, 8'h01);
      repeat (5) @(negedge clk);
      check_eq("clr_busy", busy, 1'b1);
      dbg_addr = 7'h67;
      reset    = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_vals();
      reset = 1'b0;
      t0    = cyc;
      wait_idle();
      check_eq("init_len2", cyc - t0, 100);
      peek(7'h67, 8'h20, "refill_67");
      peek(7'h00, 8'h20, "refill_00");
      bus_read(1'b0, rd);
      check_eq("bf_after_rst", rd, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
